// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream valid/ready + fields,
// downstream valid/ready + fields, flush and perf/debug observation.
interface pipe_skid_reg_if #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 128,
   parameter int PC_W   = 64,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic [PC_W-1:0]   in_pc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [PC_W-1:0]   out_pc;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  bp_cnt;

   modport slave (
      input  in_valid, in_ctrl, in_data, in_pc, flush, out_ready,
      output in_ready, out_valid, out_ctrl, out_data, out_pc, occupancy, bp_cnt
   );

   modport master (
      output in_valid, in_ctrl, in_data, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data, out_pc, occupancy, bp_cnt
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with a one-entry skid buffer behind a valid/ready handshake.
// Bubbles zero ctrl/pc but keep the payload; flush discards everything held or arriving.
module pipe_skid_reg #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 128,
   parameter int PC_W   = 64,
   parameter int CNT_W  = 16
) (
   input  logic           clk,
   input  logic           rst,
   pipe_skid_reg_if.slave bus
);
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_MAIN  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] BP_MAX = '1;

   state_t            state_q, state_d;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              accept;
   logic              drain;

   logic              ld_main_in;
   logic              ld_main_skid;
   logic              ld_skid;
   logic              bubble_main;
   logic              clr_skid;

   logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
   logic [DATA_W-1:0] main_data_q, skid_data_q;
   logic [PC_W-1:0]   main_pc_q,   skid_pc_q;
   logic [CNT_W-1:0]  bp_cnt_q,    bp_cnt_d;

   assign accept = bus.in_valid & in_ready_q;
   assign drain  = out_valid_q & bus.out_ready;

   // Handshake flags are registered from state_d so both ready and valid leave flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != ST_FULL);
         out_valid_q <= (state_d != ST_EMPTY);
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) state_d = ST_MAIN;
            ST_MAIN: begin
               if (accept && !drain)      state_d = ST_FULL;
               else if (!accept && drain) state_d = ST_EMPTY;
            end
            ST_FULL:  if (drain) state_d = ST_MAIN;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      bubble_main  = 1'b0;
      clr_skid     = 1'b0;
      if (bus.flush) begin
         bubble_main = 1'b1;
         clr_skid    = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: ld_main_in = accept;
            ST_MAIN: begin
               ld_main_in  = accept & drain;
               ld_skid     = accept & ~drain;
               bubble_main = ~accept & drain;
            end
            ST_FULL: begin
               ld_main_skid = drain;
               clr_skid     = drain;
            end
            default: bubble_main = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_ctrl_q <= '0;
         main_data_q <= '0;
         main_pc_q   <= '0;
      end else if (bubble_main) begin
         main_ctrl_q <= '0;
         main_pc_q   <= '0;
      end else if (ld_main_in) begin
         main_ctrl_q <= bus.in_ctrl;
         main_data_q <= bus.in_data;
         main_pc_q   <= bus.in_pc;
      end else if (ld_main_skid) begin
         main_ctrl_q <= skid_ctrl_q;
         main_data_q <= skid_data_q;
         main_pc_q   <= skid_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_pc_q   <= '0;
      end else if (ld_skid) begin
         skid_ctrl_q <= bus.in_ctrl;
         skid_data_q <= bus.in_data;
         skid_pc_q   <= bus.in_pc;
      end else if (clr_skid) begin
         skid_ctrl_q <= '0;
         skid_pc_q   <= '0;
      end
   end

   // Stall counter deliberately ignores flush; only reset clears it.
   always_comb begin
      bp_cnt_d = bp_cnt_q;
      if (out_valid_q && !bus.out_ready && (bp_cnt_q != BP_MAX))
         bp_cnt_d = bp_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) bp_cnt_q <= '0;
      else     bp_cnt_q <= bp_cnt_d;
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ctrl  = main_ctrl_q;
   assign bus.out_data  = main_data_q;
   assign bus.out_pc    = main_pc_q;
   assign bus.occupancy = state_q;
   assign bus.bp_cnt    = bp_cnt_q;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: vector table, directed corner sequences,
// then random traffic against a queue-based reference model.
module tb_pipe_skid_reg;
   localparam int CW = 16;
   localparam int DW = 128;
   localparam int PW = 64;
   localparam int NW = 4;
   localparam logic [NW-1:0] BP_MAX = '1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW), .CNT_W(NW)) bus ();

   pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW), .CNT_W(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
      logic [PW-1:0] pc;
   } entry_t;

   typedef struct {
      bit            r;
      bit            iv;
      logic [CW-1:0] ic;
      logic [DW-1:0] id;
      logic [PW-1:0] ipc;
      bit            ordy;
      bit            fl;
      bit            ev;
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      logic [PW-1:0] epc;
      logic [1:0]    eocc;
      bit            eir;
      logic [NW-1:0] ebp;
   } vec_t;

   entry_t        mq[$];
   logic [DW-1:0] m_disp;
   logic [NW-1:0] m_bp;
   int            checks;
   int            failures;
   vec_t          vt[18];

   function automatic logic [DW-1:0] dat(input int n);
      return {4{32'hDA7A_0000 + 32'(n)}};
   endfunction

   function automatic vec_t mk(input bit r, input bit iv, input logic [CW-1:0] ic,
                               input logic [DW-1:0] id, input logic [PW-1:0] ipc,
                               input bit ordy, input bit fl, input bit ev,
                               input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                               input logic [PW-1:0] epc, input logic [1:0] eocc,
                               input bit eir, input logic [NW-1:0] ebp);
      vec_t v;
      v.r = r; v.iv = iv; v.ic = ic; v.id = id; v.ipc = ipc; v.ordy = ordy; v.fl = fl;
      v.ev = ev; v.ec = ec; v.ed = ed; v.epc = epc; v.eocc = eocc; v.eir = eir; v.ebp = ebp;
      return v;
   endfunction

   // Reference: the stage is a FIFO of depth 2; the visible payload is the head, or the
   // last head seen once the stage has emptied.
   task automatic model_edge(input bit r, input bit iv, input entry_t e, input bit ordy, input bit fl);
      bit rdy, ov, acc, drn;
      entry_t head;
      if (r) begin
         mq.delete();
         m_disp = '0;
         m_bp   = '0;
         return;
      end
      rdy = (mq.size() < 2);
      ov  = (mq.size() > 0);
      acc = iv && rdy;
      drn = ov && ordy;
      if (ov && !ordy && m_bp != BP_MAX) m_bp = m_bp + 1'b1;
      if (drn) begin
         head = mq.pop_front();
         $display("drain pc=%0h ctrl=%0h", head.pc, head.ctrl);
      end
      if (acc) mq.push_back(e);
      if (fl) mq.delete();
      if (mq.size() > 0) m_disp = mq[0].data;
   endtask

   task automatic drive(input bit r, input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic [PW-1:0] p, input bit ordy, input bit fl);
      entry_t e;
      e.ctrl = c; e.data = d; e.pc = p;
      rst           = r;
      bus.in_valid  = iv;
      bus.in_ctrl   = c;
      bus.in_data   = d;
      bus.in_pc     = p;
      bus.out_ready = ordy;
      bus.flush     = fl;
      model_edge(r, iv, e, ordy, fl);
      @(negedge clk);
   endtask

   task automatic cmp(input string tag, input string fld, input logic [DW-1:0] got, input logic [DW-1:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s %s got=%0h want=%0h", tag, fld, got, want);
      end
   endtask

   task automatic check_vals(input string tag, input bit ev, input logic [CW-1:0] ec,
                             input logic [DW-1:0] ed, input logic [PW-1:0] epc,
                             input logic [1:0] eocc, input bit eir, input logic [NW-1:0] ebp);
      cmp(tag, "out_valid", DW'(bus.out_valid), DW'(ev));
      cmp(tag, "out_ctrl",  DW'(bus.out_ctrl),  DW'(ec));
      cmp(tag, "out_data",  bus.out_data,       ed);
      cmp(tag, "out_pc",    DW'(bus.out_pc),    DW'(epc));
      cmp(tag, "occupancy", DW'(bus.occupancy), DW'(eocc));
      cmp(tag, "in_ready",  DW'(bus.in_ready),  DW'(eir));
      cmp(tag, "bp_cnt",    DW'(bus.bp_cnt),    DW'(ebp));
   endtask

   task automatic check_model(input string tag);
      bit            ev;
      logic [CW-1:0] ec;
      logic [PW-1:0] ep;
      ev = (mq.size() > 0);
      ec = ev ? mq[0].ctrl : '0;
      ep = ev ? mq[0].pc   : '0;
      check_vals(tag, ev, ec, m_disp, ep, 2'(mq.size()), mq.size() < 2, m_bp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] dead;
      checks   = 0;
      failures = 0;
      m_disp   = '0;
      m_bp     = '0;
      dead     = {4{32'hDEAD_BEEF}};

      drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      check_vals("reset", 1'b0, '0, '0, '0, 2'd0, 1'b1, '0);

      // skid fill / drain in order
      vt[0]  = mk(0, 1, 16'h0011, dat(1), 64'h100, 1, 0,  1, 16'h0011, dat(1), 64'h100, 2'd1, 1, 4'd0);
      vt[1]  = mk(0, 1, 16'h0022, dat(2), 64'h104, 0, 0,  1, 16'h0011, dat(1), 64'h100, 2'd2, 0, 4'd1);
      vt[2]  = mk(0, 0, '0, '0, '0,               1, 0,  1, 16'h0022, dat(2), 64'h104, 2'd1, 1, 4'd1);
      vt[3]  = mk(0, 0, '0, '0, '0,               1, 0,  0, '0,       dat(2), '0,      2'd0, 1, 4'd1);
      // flush while FULL with a new entry presented
      vt[4]  = mk(0, 1, 16'h0033, dat(3), 64'h200, 0, 0,  1, 16'h0033, dat(3), 64'h200, 2'd1, 1, 4'd1);
      vt[5]  = mk(0, 1, 16'h0044, dat(4), 64'h204, 0, 0,  1, 16'h0033, dat(3), 64'h200, 2'd2, 0, 4'd2);
      vt[6]  = mk(0, 1, 16'h0055, dat(5), 64'h208, 0, 1,  0, '0,       dat(3), '0,      2'd0, 1, 4'd3);
      vt[7]  = mk(0, 0, '0, '0, '0,               0, 0,  0, '0,       dat(3), '0,      2'd0, 1, 4'd3);
      // drain to empty keeps payload
      vt[8]  = mk(0, 1, 16'hFFFF, dead,  64'h300, 1, 0,  1, 16'hFFFF, dead,   64'h300, 2'd1, 1, 4'd3);
      vt[9]  = mk(0, 0, '0, '0, '0,               1, 0,  0, '0,       dead,   '0,      2'd0, 1, 4'd3);
      // flush with simultaneous accept and drain
      vt[10] = mk(0, 1, 16'h0066, dat(6), 64'h400, 1, 0,  1, 16'h0066, dat(6), 64'h400, 2'd1, 1, 4'd3);
      vt[11] = mk(0, 1, 16'h0077, dat(7), 64'h404, 1, 1,  0, '0,       dat(6), '0,      2'd0, 1, 4'd3);
      // reset while FULL, input in FULL ignored
      vt[12] = mk(0, 1, 16'h0088, dat(8), 64'h500, 0, 0,  1, 16'h0088, dat(8), 64'h500, 2'd1, 1, 4'd3);
      vt[13] = mk(0, 1, 16'h0099, dat(9), 64'h504, 0, 0,  1, 16'h0088, dat(8), 64'h500, 2'd2, 0, 4'd4);
      vt[14] = mk(0, 1, 16'h00CC, dat(12), 64'h508, 0, 0, 1, 16'h0088, dat(8), 64'h500, 2'd2, 0, 4'd5);
      vt[15] = mk(1, 1, 16'h00AA, dat(10), 64'h50C, 0, 0, 0, '0,       '0,     '0,      2'd0, 1, 4'd0);
      vt[16] = mk(0, 1, 16'h00BB, dat(11), 64'h600, 1, 0, 1, 16'h00BB, dat(11), 64'h600, 2'd1, 1, 4'd0);
      vt[17] = mk(0, 0, '0, '0, '0,               1, 0,  0, '0,       dat(11), '0,     2'd0, 1, 4'd0);

      for (int i = 0; i < 18; i++) begin
         drive(vt[i].r, vt[i].iv, vt[i].ic, vt[i].id, vt[i].ipc, vt[i].ordy, vt[i].fl);
         $display("vec %0d rst=%0d iv=%0d pc=%0h ordy=%0d flush=%0d", i, vt[i].r, vt[i].iv, vt[i].ipc, vt[i].ordy, vt[i].fl);
         check_vals($sformatf("vec%0d", i), vt[i].ev, vt[i].ec, vt[i].ed, vt[i].epc, vt[i].eocc, vt[i].eir, vt[i].ebp);
      end

      // streaming at full rate
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b1, 16'h0100 + 16'(k), dat(100 + k), 64'h8000_0000 + 64'(4 * k), 1'b1, 1'b0);
         check_vals($sformatf("stream%0d", k), 1'b1, 16'h0100 + 16'(k), dat(100 + k),
                    64'h8000_0000 + 64'(4 * k), 2'd1, 1'b1, '0);
      end
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
      check_model("stream_end");

      // backpressure counter saturation, then reset clears it
      drive(1'b0, 1'b1, 16'h5A5A, dat(200), 64'h700, 1'b0, 1'b0);
      check_vals("sat_load", 1'b1, 16'h5A5A, dat(200), 64'h700, 2'd1, 1'b1, '0);
      for (int k = 1; k <= 20; k++) begin
         drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
         check_vals($sformatf("sat%0d", k), 1'b1, 16'h5A5A, dat(200), 64'h700, 2'd1, 1'b1,
                    (k > 15) ? 4'd15 : 4'(k));
      end
      drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      check_vals("sat_rst", 1'b0, '0, '0, '0, 2'd0, 1'b1, '0);

      // random traffic against the reference model
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 70,
               16'($urandom),
               {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom},
               $urandom_range(0, 99) < 60,
               $urandom_range(0, 99) < 5);
         check_model($sformatf("rand%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised inter-stage pipeline register that replaces fixed-field, stall-code-driven stage registers such as the EX/ME register.
- Carries a zero-on-bubble control field, a hold-on-bubble payload field and a PC.
- Uses a valid/ready handshake with a one-entry skid buffer, so backpressure is fully registered and no throughput is lost.
- Adds a flush input, an occupancy output and a saturating backpressure counter for perf/debug.

Parameters:
CTRL_W, 16, width of control bits (wena/rena/branch/jump/valid-type flags); forced to 0 whenever the stage holds a bubble
DATA_W, 128, width of payload (alu result, store data, byte enables, rd addr, inst, ...); never cleared except by reset
PC_W, 64, width of PC field; forced to 0 on bubble
CNT_W, 16, width of backpressure counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_ctrl  in  CTRL_W  upstream control
in_data  in  DATA_W  upstream payload
in_pc  in  PC_W  upstream PC
flush  in  1  kill all held entries and any entry presented this cycle
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  main control (0 when !out_valid)
out_data  out  DATA_W  main payload
out_pc  out  PC_W  main PC (0 when !out_valid)
occupancy  out  2  entries held: 0, 1 or 2
bp_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: state EMPTY. out_valid=0, out_ctrl=0, out_data=0, out_pc=0, occupancy=0, bp_cnt=0, in_ready=1 from the first cycle after reset. Skid registers are cleared.
- Storage: main register (drives out_*) and skid register. All outputs come straight from flops; there is no combinational in-to-out path.
- States: EMPTY (occ 0), MAIN (occ 1), FULL (occ 2). in_ready=1 in EMPTY/MAIN, 0 in FULL.
- Accept: in_valid & in_ready. Drain: out_valid & out_ready.
- EMPTY:
  - accept -> MAIN, main<=in. Latency 1 cycle in->out.
- MAIN:
  - accept & drain -> MAIN, main<=in.
  - accept & !drain -> FULL, skid<=in.
  - !accept & drain -> EMPTY.
  - neither -> hold.
- FULL:
  - drain -> MAIN, main<=skid; skid ctrl/pc cleared.
  - else hold. No accept is possible.
- Bubble rule: on any transition to EMPTY (drain or flush), main ctrl and pc are set to 0 and main data holds its last value. skid_valid clears whenever skid empties.
- Flush has highest priority:
  - next state EMPTY, both entries killed.
  - A same-cycle accept handshake is discarded (upstream sees a transfer, the entry is dropped).
  - A same-cycle drain still counts downstream as a transfer.
  - bp_cnt is unaffected by flush.
- Data ordering is strictly FIFO: the skid entry is always older than any later accept.
- bp_cnt increments by 1 each cycle out_valid & !out_ready, sticks at 2^CNT_W-1, and clears only on rst.
- No state may change when in_valid=0, out_valid=0 and flush=0.
- in_valid may be asserted in FULL; the stage ignores it, and upstream must hold it.
- Reset mid-operation: all entries are lost, and outputs follow the reset values on the next edge.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 8 cycles with pc 0x80000000+4k. -> Outputs appear 1 cycle later in order, occupancy=1 throughout, in_ready=1, bp_cnt=0.
- Skid fill: accept A (pc 0x100); next cycle out_ready=0 while B (pc 0x104) is presented. -> occupancy=2, in_ready=0, out_pc=0x100 held. Then raise out_ready. -> out 0x100 then 0x104, no loss or duplication, bp_cnt=1.
- Flush in FULL with simultaneous in_valid C. -> Next cycle out_valid=0, out_ctrl=0, out_pc=0, out_data unchanged, occupancy=0, C never appears.
- Drain to empty: single entry with ctrl=0xFFFF, data=0xDEAD…, out_ready=1, no new input. -> Next cycle ctrl=0, pc=0, data still 0xDEAD…
- bp_cnt saturation with CNT_W=4: out_valid held, out_ready=0 for 20 cycles. -> bp_cnt climbs to 15 and stays; rst clears it to 0.
- Reset while FULL. -> Next cycle all outputs 0, in_ready=1, occupancy=0; a subsequent accept emerges normally after 1 cycle.
